// File: rtl/padding_ctrl.sv
// -----------------------------------------------------------------------------
// padding_ctrl
//
// Sequencer for the byte-wise SHA-256 padding datapath. It performs three jobs:
//   1. Accepts a message byte stream (s_valid/s_ready) and writes each byte
//      into the padding unit.
//   2. Commands the 0x80 pad-byte write and the two length-byte writes.
//   3. Streams the padded 512-bit block(s) to the hash core as 32-bit words
//      (w_valid/w_ready).
//
// Parameters
//   MAX_MSG_BYTES : largest accepted message (1..55 -> 1 block, 56..119 -> 2)
//   CNT_W         : width of the message byte counter
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   s_valid/s_data/s_last/s_ready : message byte stream
//   pad_rst         : clears the padding unit
//   pad_en          : padding byte-write strobe
//   pad_data_valid  : 1 = write pad_data, 0 = write the 0x80 pad byte
//   pad_data        : message byte passed through to the padding unit
//   pad_len_sel     : length-field write
//   pad_select      : length byte select (0 = high, 1 = low)
//   pad_addr_rd     : padded-word read index (0 outside the output phase)
//   pad_blocks_num  : from padding unit, 0 = one block, otherwise two
//   pad_word        : padded word at pad_addr_rd
//   w_valid/w_data/w_first/w_last/w_ready : word stream to the hash core
//   busy            : controller is not idle
//   err             : one-cycle overflow pulse (only with the macro below)
//
// Build option
//   PADCTRL_OVF_CHECK_EN : when defined, a byte arriving while the counter is
//   already at MAX_MSG_BYTES raises err (registered, one cycle) and the rest
//   of the message is drained without producing any words. When undefined,
//   err is tied low and surplus bytes are silently dropped (the message is
//   padded as if truncated to MAX_MSG_BYTES).
// -----------------------------------------------------------------------------
module padding_ctrl #(
   parameter int MAX_MSG_BYTES = 119,
   parameter int CNT_W         = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic        pad_rst,
   output logic        pad_en,
   output logic        pad_data_valid,
   output logic [7:0]  pad_data,
   output logic        pad_len_sel,
   output logic        pad_select,
   output logic [4:0]  pad_addr_rd,
   input  logic [1:0]  pad_blocks_num,
   input  logic [31:0] pad_word,
   output logic        w_valid,
   output logic [31:0] w_data,
   output logic        w_first,
   output logic        w_last,
   input  logic        w_ready,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PAD   = 3'd3,
      ST_LENH  = 3'd4,
      ST_LENL  = 3'd5,
      ST_OUT   = 3'd6
`ifdef PADCTRL_OVF_CHECK_EN
      ,
      ST_DRAIN = 3'd7
`endif
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MSG_BYTES);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] byte_cnt_r;
   logic [4:0]       widx_r;

   logic             s_acc_s;
   logic             w_acc_s;
   logic             cnt_full_s;
   logic [4:0]       last_widx_s;
   logic             w_last_s;

   assign s_acc_s     = s_valid & s_ready;
   assign w_acc_s     = w_valid & w_ready;
   assign cnt_full_s  = (byte_cnt_r == CNT_MAX);
   // Any non-zero block count from the padding unit is treated as two blocks.
   assign last_widx_s = (pad_blocks_num == 2'd0) ? 5'd15 : 5'd31;
   assign w_last_s    = (widx_r == last_widx_s);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            // The waiting byte is left unconsumed; CLR runs first.
            if (s_valid) begin
               state_nxt_s = ST_CLR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CLR: begin
            state_nxt_s = ST_LOAD;
         end
         ST_LOAD: begin
            if (s_acc_s) begin
`ifdef PADCTRL_OVF_CHECK_EN
               if (cnt_full_s) begin
                  // Overflowing byte: abandon the message. If it is also the
                  // final byte there is nothing left to drain.
                  if (s_last) begin
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_DRAIN;
                  end
               end else if (s_last) begin
                  state_nxt_s = ST_PAD;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
`else
               if (s_last) begin
                  state_nxt_s = ST_PAD;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
`endif
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_PAD: begin
            state_nxt_s = ST_LENH;
         end
         ST_LENH: begin
            state_nxt_s = ST_LENL;
         end
         ST_LENL: begin
            state_nxt_s = ST_OUT;
         end
         ST_OUT: begin
            if (w_acc_s && w_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
`ifdef PADCTRL_OVF_CHECK_EN
         ST_DRAIN: begin
            if (s_acc_s && s_last) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
`endif
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the current state (and the live byte handshake in LOAD).
   always_comb begin
      s_ready        = 1'b0;
      pad_rst        = 1'b0;
      pad_en         = 1'b0;
      pad_data_valid = 1'b0;
      pad_data       = 8'h00;
      pad_len_sel    = 1'b0;
      pad_select     = 1'b0;
      pad_addr_rd    = 5'd0;
      w_valid        = 1'b0;
      w_data         = 32'h0000_0000;
      w_first        = 1'b0;
      w_last         = 1'b0;
      busy           = (state_r != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_CLR: begin
            pad_rst = 1'b1;
         end
         ST_LOAD: begin
            s_ready  = 1'b1;
            pad_data = s_data;
            if (s_valid) begin
               pad_data_valid = 1'b1;
               // A byte beyond capacity is accepted but never written.
               pad_en         = ~cnt_full_s;
            end else begin
               pad_data_valid = 1'b0;
               pad_en         = 1'b0;
            end
         end
         ST_PAD: begin
            pad_en         = 1'b1;
            pad_data_valid = 1'b0;
         end
         ST_LENH: begin
            pad_len_sel = 1'b1;
            pad_select  = 1'b0;
         end
         ST_LENL: begin
            pad_len_sel = 1'b1;
            pad_select  = 1'b1;
         end
         ST_OUT: begin
            // widx only moves on a handshake, so address and data hold
            // steady for as long as the hash core stalls.
            w_valid     = 1'b1;
            pad_addr_rd = widx_r;
            w_data      = pad_word;
            w_first     = (widx_r[3:0] == 4'd0);
            w_last      = w_last_s;
         end
`ifdef PADCTRL_OVF_CHECK_EN
         ST_DRAIN: begin
            s_ready = 1'b1;
         end
`endif
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Message byte counter: cleared per message, saturates at capacity.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_CLR) begin
         byte_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_LOAD) && s_acc_s && !cnt_full_s) begin
         byte_cnt_r <= byte_cnt_r + CNT_W'(1);
      end else begin
         byte_cnt_r <= byte_cnt_r;
      end
   end

   // Output word index: advances on each accepted word, zero outside OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         widx_r <= 5'd0;
      end else if (state_r != ST_OUT) begin
         widx_r <= 5'd0;
      end else if (w_acc_s) begin
         if (w_last_s) begin
            widx_r <= 5'd0;
         end else begin
            widx_r <= widx_r + 5'd1;
         end
      end else begin
         widx_r <= widx_r;
      end
   end

`ifdef PADCTRL_OVF_CHECK_EN
   logic err_r;

   // Overflow flag: pulses for the cycle following the overflowing accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (state_r == ST_LOAD) && s_acc_s && cnt_full_s;
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_padding_ctrl.sv
// -----------------------------------------------------------------------------
// tb_padding_ctrl
//
// Directed bench for padding_ctrl. A small behavioural padding unit sits
// behind the controller so that real padded words come back on pad_word;
// expected words are hand-computed constants. A table of message vectors is
// applied in a loop, followed by hand-written sequences for reset during
// output, back-to-back messages and message overflow.
// -----------------------------------------------------------------------------
module tb_padding_ctrl;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic        pad_rst;
   logic        pad_en;
   logic        pad_data_valid;
   logic [7:0]  pad_data;
   logic        pad_len_sel;
   logic        pad_select;
   logic [4:0]  pad_addr_rd;
   logic [1:0]  pad_blocks_num;
   logic [31:0] pad_word;
   logic        w_valid;
   logic [31:0] w_data;
   logic        w_first;
   logic        w_last;
   logic        w_ready;
   logic        busy;
   logic        err;

   padding_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .s_last         (s_last),
      .s_ready        (s_ready),
      .pad_rst        (pad_rst),
      .pad_en         (pad_en),
      .pad_data_valid (pad_data_valid),
      .pad_data       (pad_data),
      .pad_len_sel    (pad_len_sel),
      .pad_select     (pad_select),
      .pad_addr_rd    (pad_addr_rd),
      .pad_blocks_num (pad_blocks_num),
      .pad_word       (pad_word),
      .w_valid        (w_valid),
      .w_data         (w_data),
      .w_first        (w_first),
      .w_last         (w_last),
      .w_ready        (w_ready),
      .busy           (busy),
      .err            (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural padding unit ----------------
   logic [7:0]  mem [0:127];
   logic [7:0]  pm_cnt = 8'd0;
   logic [7:0]  pm_len = 8'd0;
   logic [15:0] pm_bits;
   logic [6:0]  pm_lo_idx;

   assign pm_bits        = {5'd0, pm_len, 3'd0};
   assign pm_lo_idx      = (pm_len >= 8'd56) ? 7'd127 : 7'd63;
   assign pad_blocks_num = (pm_len >= 8'd56) ? 2'd1 : 2'd0;
   assign pad_word = {mem[{pad_addr_rd, 2'b00}], mem[{pad_addr_rd, 2'b01}],
                      mem[{pad_addr_rd, 2'b10}], mem[{pad_addr_rd, 2'b11}]};

   always @(posedge clk) begin
      if (pad_rst) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
         pm_cnt <= 8'd0;
         pm_len <= 8'd0;
      end else if (pad_en && pad_data_valid) begin
         mem[pm_cnt[6:0]] <= pad_data;
         pm_cnt <= pm_cnt + 8'd1;
      end else if (pad_en) begin
         mem[pm_cnt[6:0]] <= 8'h80;
         pm_len <= pm_cnt;
      end else if (pad_len_sel && !pad_select) begin
         mem[pm_lo_idx - 7'd1] <= pm_bits[15:8];
      end else if (pad_len_sel) begin
         mem[pm_lo_idx] <= pm_bits[7:0];
      end
   end

   // ---------------- monitor (samples on falling edge) ----------------
   logic [31:0] wq_data  [$];
   bit          wq_first [$];
   bit          wq_last  [$];
   int          prst_cnt   = 0;
   int          bwr_cnt    = 0;
   int          err_cnt    = 0;
   int          wv_cnt     = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = 32'h0;

   always @(negedge clk) begin
      if (pad_rst) prst_cnt <= prst_cnt + 1;
      if (pad_en && pad_data_valid) bwr_cnt <= bwr_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (w_valid) wv_cnt <= wv_cnt + 1;
      if (w_valid && w_ready && !rst) begin
         wq_data.push_back(w_data);
         wq_first.push_back(w_first);
         wq_last.push_back(w_last);
      end
      if (!rst && prev_stall && (!w_valid || (w_data !== prev_data)))
         stall_viol <= stall_viol + 1;
      prev_stall <= w_valid && !w_ready && !rst;
      prev_data  <= w_data;
   end

   // ---------------- w_ready generator ----------------
   bit stall_mode = 1'b0;
   int ph;

   initial begin
      w_ready = 1'b1;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode) begin
            w_ready = (ph == 0);
            ph = (ph == 2) ? 0 : ph + 1;
         end else begin
            w_ready = 1'b1;
            ph = 0;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_word(input int idx);
      if (idx < wq_data.size()) return wq_data[idx];
      else return 32'hDEAD_BEEF;
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic last, output bit ok);
      int t;
      t = 0;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (t < 100 && !ok) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   task automatic send_msg(input int len, input bit abc, input logic [7:0] fill, output int nto);
      bit ok;
      nto = 0;
      for (int i = 0; i < len; i++) begin
         send_byte(abc ? 8'(8'h61 + i) : fill, (i == len - 1), ok);
         if (!ok) nto++;
      end
   endtask

   task automatic wait_words(input int base, input int n);
      int t;
      t = 0;
      while ((wq_data.size() - base) < n && t < 1000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          len;
      bit          abc;
      logic [7:0]  fill;
      bit          stall;
      int          exp_n;
      logic [31:0] exp_w0;
      int          k;
      logic [31:0] exp_wk;
      logic [31:0] exp_wlast;
   } vec_t;

   task automatic run_entry(input vec_t v);
      int base, p0, b0, s0, e0, nto, lat, nw, fl_bad;
      base = wq_data.size();
      p0 = prst_cnt; b0 = bwr_cnt; s0 = stall_viol; e0 = err_cnt;
      stall_mode = v.stall;
      send_msg(v.len, v.abc, v.fill, nto);
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("byte_accept_timeouts", nto, 0);
      lat = 0;
      while (lat < 50) begin
         @(negedge clk);
         if (w_valid) break;
         lat++;
      end
      chk("latency_to_w_valid", lat, 3);
      wait_words(base, v.exp_n);
      nw = wq_data.size() - base;
      chk("word_count", nw, v.exp_n);
      chk("word0", get_word(base), v.exp_w0);
      chk("word_k", get_word(base + v.k), v.exp_wk);
      chk("word_last", get_word(base + v.exp_n - 1), v.exp_wlast);
      if (nw > v.exp_n) nw = v.exp_n;
      fl_bad = 0;
      for (int j = 0; j < nw; j++) begin
         if (wq_first[base + j] !== ((j % 16) == 0)) fl_bad++;
         if (wq_last[base + j] !== (j == v.exp_n - 1)) fl_bad++;
      end
      chk("first_last_flags", fl_bad, 0);
      @(negedge clk);
      chk("busy_after_msg", busy, 0);
      chk("pad_rst_cycles", prst_cnt - p0, 1);
      chk("bytes_written", bwr_cnt - b0, v.len);
      chk("stall_stability", stall_viol - s0, 0);
      chk("err_pulses", err_cnt - e0, 0);
      stall_mode = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   vec_t vt [6];

   initial begin
      int base, p0, b0, e0, w0c, nto, t, bad;

      vt[0] = '{3,  1'b1, 8'h00, 1'b0, 16, 32'h61626380, 1,  32'h00000000, 32'h00000018};
      vt[1] = '{56, 1'b0, 8'h00, 1'b0, 32, 32'h00000000, 14, 32'h80000000, 32'h000001C0};
      vt[2] = '{3,  1'b1, 8'h00, 1'b1, 16, 32'h61626380, 1,  32'h00000000, 32'h00000018};
      vt[3] = '{55, 1'b0, 8'h11, 1'b0, 16, 32'h11111111, 13, 32'h11111180, 32'h000001B8};
      vt[4] = '{1,  1'b0, 8'hA5, 1'b0, 16, 32'hA5800000, 1,  32'h00000000, 32'h00000008};
      vt[5] = '{56, 1'b0, 8'h00, 1'b1, 32, 32'h00000000, 14, 32'h80000000, 32'h000001C0};

      rst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'h00;
      s_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl_outputs",
          {23'd0, busy, w_valid, s_ready, pad_rst, pad_en, pad_len_sel, err, w_first, w_last}, 32'h0);
      chk("reset_addr", pad_addr_rd, 0);
      chk("reset_w_data", w_data, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) run_entry(vt[i]);

      // Reset while streaming word 5.
      base = wq_data.size();
      send_msg(3, 1'b1, 8'h00, nto);
      s_valid = 1'b0;
      s_last = 1'b0;
      t = 0;
      while ((wq_data.size() - base) < 5 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("addr_before_reset", pad_addr_rd, 5);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("w_valid_after_reset", w_valid, 0);
      chk("busy_after_reset", busy, 0);
      chk("addr_after_reset", pad_addr_rd, 0);
      @(posedge clk);
      #1;
      run_entry(vt[0]);

      // Two messages back-to-back with s_valid held high.
      base = wq_data.size();
      p0 = prst_cnt;
      send_msg(3, 1'b1, 8'h00, nto);
      send_msg(3, 1'b1, 8'h00, t);
      s_valid = 1'b0;
      s_last = 1'b0;
      chk("b2b_accept_timeouts", nto + t, 0);
      wait_words(base, 32);
      chk("b2b_word_count", wq_data.size() - base, 32);
      chk("b2b_pad_rst_cycles", prst_cnt - p0, 2);
      bad = 0;
      for (int j = 0; j < 16; j++)
         if (get_word(base + j) !== get_word(base + 16 + j)) bad++;
      chk("b2b_identical", bad, 0);
      chk("b2b_w0", get_word(base), 32'h61626380);
      chk("b2b_w31", get_word(base + 31), 32'h00000018);
      chk("b2b_last_flags", {30'd0, (wq_last.size() > base + 31) ? wq_last[base + 15] : 1'b0,
                                   (wq_last.size() > base + 31) ? wq_last[base + 31] : 1'b0}, 32'h3);

`ifdef PADCTRL_OVF_CHECK_EN
      // 120-byte message: overflow on the final byte, no words.
      w0c = wv_cnt; e0 = err_cnt; b0 = bwr_cnt;
      send_msg(120, 1'b0, 8'h00, nto);
      s_valid = 1'b0;
      s_last = 1'b0;
      @(negedge clk);
      chk("ovf_err_pulse", err, 1);
      chk("ovf_busy_after_last", busy, 0);
      repeat (30) @(posedge clk);
      #1;
      chk("ovf_err_count", err_cnt - e0, 1);
      chk("ovf_no_w_valid", wv_cnt - w0c, 0);
      chk("ovf_bytes_written", bwr_cnt - b0, 119);
      // 122-byte message: drains the tail, one err pulse, no words.
      w0c = wv_cnt; e0 = err_cnt;
      send_msg(122, 1'b0, 8'h00, nto);
      s_valid = 1'b0;
      s_last = 1'b0;
      chk("drain_accept_timeouts", nto, 0);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("drain_err_count", err_cnt - e0, 1);
      chk("drain_no_w_valid", wv_cnt - w0c, 0);
      chk("drain_busy", busy, 0);
`else
      // 120-byte message: surplus byte dropped, padded as 119 bytes.
      base = wq_data.size();
      e0 = err_cnt; b0 = bwr_cnt;
      send_msg(120, 1'b0, 8'h00, nto);
      s_valid = 1'b0;
      s_last = 1'b0;
      chk("trunc_accept_timeouts", nto, 0);
      wait_words(base, 32);
      w0c = wq_data.size() - base;
      chk("trunc_word_count", w0c, 32);
      chk("trunc_w29", get_word(base + 29), 32'h00000080);
      chk("trunc_w31", get_word(base + 31), 32'h000003B8);
      chk("trunc_bytes_written", bwr_cnt - b0, 119);
      chk("trunc_no_err", err_cnt - e0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
